// File: rtl/grid_arb_pkg.sv
// ---------------------------------------------------------------------------
// grid_arb_pkg
// Shared definitions for the grid port arbiter: default sizing, the value
// that marks an empty grid cell, request opcodes, the FSM state encoding and
// two small decode helpers used when a request is latched.
// ---------------------------------------------------------------------------
package grid_arb_pkg;

    // Default sizing: four requesters, 32-bit cells, a 12x12 grid.
    localparam int NREQ  = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 144;
    localparam int AW    = 12;

    // A cell holding all ones is free and may be claimed.
    localparam logic signed [31:0] EMPTY_CELL = -32'sd1;

    // Request opcodes.
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_CLAIM = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    // Transaction sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_CLAIM_WR = 3'd3,
        ST_DONE     = 3'd4
    } arb_state_e;

    // The reserved opcode behaves exactly like a read.
    function automatic logic [1:0] norm_op(input logic [1:0] op);
        case (op)
            OP_WRITE:          return OP_WRITE;
            OP_CLAIM:          return OP_CLAIM;
            OP_READ, OP_RSVD:  return OP_READ;
            default:           return OP_READ;
        endcase
    endfunction

    // Cell indices are signed: negative values and values at or above the
    // grid size never reach memory.
    function automatic logic addr_in_range(input logic [31:0] a,
                                           input int unsigned depth);
        return (a[31] == 1'b0) && (a < depth);
    endfunction

endpackage

// File: rtl/grid_port_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin selector. Starting at i_ptr and walking
// upward (wrapping at N), the first asserted request wins.
//   i_req    : request vector
//   i_ptr    : index with highest priority this round
//   o_onehot : one-hot winner (all zero when nothing requests)
//   o_idx    : binary index of the winner
//   o_valid  : at least one request present
// ---------------------------------------------------------------------------
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    logic [IW-1:0] w_cand;

    // Scan the requesters in rotated order and keep the first hit.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        w_cand   = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = IW'((int'(i_ptr) + k) % N);
            if (!o_valid && i_req[w_cand]) begin
                o_valid          = 1'b1;
                o_idx            = w_cand;
                o_onehot[w_cand] = 1'b1;
            end else begin
                o_valid = o_valid;
            end
        end
    end

endmodule

// File: rtl/grid_port_arbiter.sv
// ---------------------------------------------------------------------------
// grid_port_arbiter
// Serialises grid-cell accesses from NREQ requesters onto one memory port.
// Only one transaction is in flight, which makes the read-check-write of a
// claim atomic with respect to every other requester.
//
// Ports
//   clk, reset        : rising-edge clock, synchronous active-low reset
//   req[NREQ]         : request, held until the matching gnt pulse
//   op[2*NREQ]        : 00 read, 01 write, 10 claim, 11 read
//   addr[32*NREQ]     : signed cell index per requester
//   wdata[DW*NREQ]    : write / claim data per requester
//   gnt[NREQ]         : one-cycle one-hot pulse when a request is accepted
//   done[NREQ]        : one-cycle one-hot completion pulse
//   rdata, claim_ok,
//   addr_err          : results, updated on completion and held until the next
//   mem_read/mem_write,
//   mem_addr, mem_din : memory strobes, address and write data
//   mem_dout          : memory read data, valid the cycle after mem_read
//   busy              : high whenever the sequencer is not idle
//
// Latency from the idle cycle that samples req: write 2, read 3,
// failed claim 3, successful claim 4, address error 2.
// ---------------------------------------------------------------------------
module grid_port_arbiter #(
    parameter int NREQ  = grid_arb_pkg::NREQ,
    parameter int DW    = grid_arb_pkg::DW,
    parameter int DEPTH = grid_arb_pkg::DEPTH,
    parameter int AW    = grid_arb_pkg::AW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    op,
    input  logic [32*NREQ-1:0]   addr,
    input  logic [DW*NREQ-1:0]   wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [DW-1:0]        rdata,
    output logic                 claim_ok,
    output logic                 addr_err,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_din,
    input  logic [DW-1:0]        mem_dout,
    output logic                 busy
);

    import grid_arb_pkg::*;

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Empty marker at the configured data width (sign-extends the all-ones value).
    localparam logic [DW-1:0] L_EMPTY = DW'(EMPTY_CELL);

    // Sequencer state and latched transaction fields.
    arb_state_e      r_state;
    logic [IW-1:0]   r_rr;
    logic [IW-1:0]   r_win_idx;
    logic [NREQ-1:0] r_win_oh;
    logic [1:0]      r_op;
    logic            r_addr_bad;
    logic [DW-1:0]   r_rd_buf;

    // Registered outputs.
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_done;
    logic            r_mem_read;
    logic            r_mem_write;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_din;
    logic [DW-1:0]   r_rdata;
    logic            r_claim_ok;
    logic            r_addr_err;
    logic            r_busy;

    // Winner selection and its request fields.
    logic [NREQ-1:0] w_pick_oh;
    logic [IW-1:0]   w_pick_idx;
    logic            w_pick_valid;
    logic [31:0]     w_sel_addr;
    logic [1:0]      w_sel_op;
    logic [DW-1:0]   w_sel_wdata;
    logic            w_sel_in_range;
    logic [IW-1:0]   w_rr_next;

    rr_picker #(
        .N  (NREQ),
        .IW (IW)
    ) u_picker (
        .i_req    (req),
        .i_ptr    (r_rr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    assign w_sel_addr     = addr[int'(w_pick_idx)*32 +: 32];
    assign w_sel_op       = norm_op(op[int'(w_pick_idx)*2 +: 2]);
    assign w_sel_wdata    = wdata[int'(w_pick_idx)*DW +: DW];
    assign w_sel_in_range = addr_in_range(w_sel_addr, DEPTH);

    // Next round starts just after the requester that was served.
    assign w_rr_next = (r_win_idx == IW'(NREQ - 1)) ? '0 : (r_win_idx + IW'(1));

    // Transaction sequencer; every output is set on the edge entering the
    // state in which it must be visible.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_rr        <= '0;
            r_win_idx   <= '0;
            r_win_oh    <= '0;
            r_op        <= OP_READ;
            r_addr_bad  <= 1'b0;
            r_rd_buf    <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
            r_rdata     <= '0;
            r_claim_ok  <= 1'b0;
            r_addr_err  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // Pulses last one cycle unless re-asserted below.
            r_gnt       <= '0;
            r_done      <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_win_idx   <= w_pick_idx;
                        r_win_oh    <= w_pick_oh;
                        r_op        <= w_sel_op;
                        r_addr_bad  <= !w_sel_in_range;
                        r_mem_addr  <= w_sel_addr[AW-1:0];
                        r_mem_din   <= w_sel_wdata;
                        r_gnt       <= w_pick_oh;
                        // Strobes appear in ISSUE together with gnt.
                        r_mem_read  <= w_sel_in_range && (w_sel_op != OP_WRITE);
                        r_mem_write <= w_sel_in_range && (w_sel_op == OP_WRITE);
                        r_busy      <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                ST_ISSUE: begin
                    if (r_addr_bad) begin
                        r_rdata    <= '0;
                        r_claim_ok <= 1'b0;
                        r_addr_err <= 1'b1;
                        r_done     <= r_win_oh;
                        r_state    <= ST_DONE;
                    end else if (r_op == OP_WRITE) begin
                        r_rdata    <= '0;
                        r_claim_ok <= 1'b0;
                        r_addr_err <= 1'b0;
                        r_done     <= r_win_oh;
                        r_state    <= ST_DONE;
                    end else begin
                        r_state <= ST_RD_WAIT;
                    end
                end

                ST_RD_WAIT: begin
                    if ((r_op == OP_CLAIM) && (mem_dout == L_EMPTY)) begin
                        // Keep the old value aside; rdata only moves on completion.
                        r_rd_buf    <= mem_dout;
                        r_mem_write <= 1'b1;
                        r_state     <= ST_CLAIM_WR;
                    end else begin
                        r_rdata    <= mem_dout;
                        r_claim_ok <= 1'b0;
                        r_addr_err <= 1'b0;
                        r_done     <= r_win_oh;
                        r_state    <= ST_DONE;
                    end
                end

                ST_CLAIM_WR: begin
                    r_rdata    <= r_rd_buf;
                    r_claim_ok <= 1'b1;
                    r_addr_err <= 1'b0;
                    r_done     <= r_win_oh;
                    r_state    <= ST_DONE;
                end

                ST_DONE: begin
                    r_rr    <= w_rr_next;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign rdata     = r_rdata;
    assign claim_ok  = r_claim_ok;
    assign addr_err  = r_addr_err;
    assign mem_read  = r_mem_read;
    assign mem_write = r_mem_write;
    assign mem_addr  = r_mem_addr;
    assign mem_din   = r_mem_din;
    assign busy      = r_busy;

endmodule

// File: tb/tb_grid_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_grid_port_arbiter
// Directed scenarios with literal expectations, then randomized traffic.
// A transaction-level model predicts every output on every cycle.
// ---------------------------------------------------------------------------
module tb_grid_port_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 144;
    localparam int AW    = 12;

    localparam logic [1:0] OP_RD = 2'b00;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_CL = 2'b10;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [2*NREQ-1:0]   op;
    logic [32*NREQ-1:0]  addr;
    logic [DW*NREQ-1:0]  wdata;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic [DW-1:0]       rdata;
    logic                claim_ok;
    logic                addr_err;
    logic                mem_read;
    logic                mem_write;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_din;
    logic [DW-1:0]       mem_dout;
    logic                busy;

    always #5 clk = ~clk;

    grid_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .claim_ok  (claim_ok),
        .addr_err  (addr_err),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout),
        .busy      (busy)
    );

    // Initial grid contents: cell 5 holds 7, every multiple of 4 is empty.
    function automatic logic [31:0] init_val(input int a);
        if (a == 5) return 32'd7;
        else if ((a % 4) == 0) return 32'hFFFF_FFFF;
        else return 32'(a) * 32'h0101_0101 + 32'd1;
    endfunction

    // Memory attached to the DUT port.
    logic [DW-1:0] env_mem [0:4095];
    logic          mem_load;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 4096; i++) env_mem[12'(i)] <= init_val(i);
            mem_dout <= '0;
        end else begin
            if (mem_write) env_mem[mem_addr] <= mem_din;
            if (mem_read)  mem_dout <= env_mem[mem_addr];
        end
    end

    // Bookkeeping.
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   chk_en   = 1'b0;
    bit   auto_drop = 1'b1;

    // Transaction-level reference model state.
    logic [31:0] ref_mem [0:255];
    bit          m_active;
    int          m_rr;
    int          t_start, t_lat, t_win;
    logic [1:0]  t_op;
    bit          t_inr;
    logic [31:0] t_addr, t_wdata, t_rdata;
    logic [7:0]  t_cell;
    bit          t_ok, t_err;
    logic [31:0] h_rdata;
    bit          h_ok, h_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Open a new transaction in the model from the sampled request vector.
    task automatic model_start();
        bit found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int j = (m_rr + k) % NREQ;
            if (!found && req[j]) begin
                found = 1'b1;
                t_win = j;
            end
        end
        t_addr  = addr[t_win*32 +: 32];
        t_op    = op[t_win*2 +: 2];
        if (t_op == 2'b11) t_op = OP_RD;
        t_wdata = wdata[t_win*DW +: DW];
        t_inr   = ($signed(t_addr) >= 0) && ($signed(t_addr) < DEPTH);
        t_cell  = t_addr[7:0];
        t_ok    = 1'b0;
        t_err   = 1'b0;
        t_rdata = 32'd0;
        if (!t_inr) begin
            t_lat = 2; t_err = 1'b1;
        end else if (t_op == OP_WR) begin
            t_lat = 2;
        end else if (t_op == OP_RD) begin
            t_lat = 3; t_rdata = ref_mem[t_cell];
        end else begin
            t_rdata = ref_mem[t_cell];
            if (ref_mem[t_cell] == 32'hFFFF_FFFF) begin
                t_lat = 4; t_ok = 1'b1;
            end else begin
                t_lat = 3;
            end
        end
        t_start  = cyc;
        m_active = 1'b1;
    endtask

    // Predict and compare all outputs for the current cycle, then let the
    // model react to the inputs sampled at the coming edge.
    task automatic model_step();
        logic [NREQ-1:0] oh, exp_gnt, exp_done;
        bit exp_rd, exp_wr;
        int d;
        if (m_active && (cyc - t_start) > t_lat) m_active = 1'b0;
        d  = cyc - t_start;
        oh = '0;
        if (m_active) oh[t_win] = 1'b1;
        exp_gnt  = (m_active && d == 1) ? oh : '0;
        exp_done = (m_active && d == t_lat) ? oh : '0;
        exp_rd   = m_active && d == 1 && t_inr && (t_op != OP_WR);
        exp_wr   = m_active && ((d == 1 && t_inr && t_op == OP_WR) || (d == 3 && t_ok));
        if (m_active && d == t_lat) begin
            h_rdata = t_rdata; h_ok = t_ok; h_err = t_err;
            m_rr    = (t_win + 1) % NREQ;
        end
        if (exp_wr) ref_mem[t_cell] = t_wdata;
        chk("gnt", gnt, exp_gnt);
        chk("done", done, exp_done);
        chk("mem_read", mem_read, exp_rd);
        chk("mem_write", mem_write, exp_wr);
        chk("busy", busy, m_active);
        chk("rdata", rdata, h_rdata);
        chk("claim_ok", claim_ok, h_ok);
        chk("addr_err", addr_err, h_err);
        if (exp_rd || exp_wr) chk("mem_addr", mem_addr, t_addr[AW-1:0]);
        if (exp_wr) chk("mem_din", mem_din, t_wdata);
        if (!reset) begin
            m_active = 1'b0; m_rr = 0;
            h_rdata = 32'd0; h_ok = 1'b0; h_err = 1'b0;
        end else if (!m_active && req != '0) begin
            model_start();
        end
    endtask

    // One clock: compare at the falling edge, return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (chk_en) model_step();
        @(posedge clk);
        cyc++;
        #1;
        if (auto_drop) req = req & ~gnt;
    endtask

    task automatic set_req(input int i, input logic [1:0] o, input logic [31:0] a, input logic [31:0] w);
        req[i]            = 1'b1;
        op[i*2 +: 2]      = o;
        addr[i*32 +: 32]  = a;
        wdata[i*DW +: DW] = w;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 30) begin
            tick();
            n++;
        end
        chk("wait_idle", busy, 1'b0);
    endtask

    // Follow one requester's transaction; offsets are relative to c0.
    task automatic watch(input int i, input int c0, output int g_off, output int s_off,
                         output int d_off, output logic [31:0] rd, output logic ok, output logic err);
        int n = 0;
        g_off = -1; s_off = -1; d_off = -1;
        rd = 32'd0; ok = 1'b0; err = 1'b0;
        while (d_off < 0 && n < 16) begin
            tick();
            n++;
            if (gnt[i] && g_off < 0) g_off = cyc - c0;
            if ((mem_read || mem_write) && s_off < 0 && g_off >= 0) s_off = cyc - c0;
            if (done[i]) begin
                d_off = cyc - c0;
                rd = rdata; ok = claim_ok; err = addr_err;
            end
        end
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom % 10)
            0: return 32'hFFFF_FFFF;
            1: return 32'd144;
            2: return 32'd143;
            3: return 32'd0;
            4: return 32'd20;
            5: return 32'd24;
            6: return 32'h0000_1005;
            7: return 32'h8000_0000;
            default: return 32'($urandom % 144);
        endcase
    endfunction

    function automatic logic [31:0] rand_data();
        if (($urandom % 4) == 0) return 32'hFFFF_FFFF;
        else return 32'($urandom);
    endfunction

    initial begin
        int c0, g, s, d;
        logic [31:0] rd;
        logic ok, err;
        int order [5];
        int exp_order [5];
        int cnt;

        exp_order = '{0, 1, 2, 3, 0};
        reset = 1'b0; mem_load = 1'b1;
        req = '0; op = '0; addr = '0; wdata = '0;
        m_active = 1'b0; m_rr = 0; t_start = 0; t_lat = 0; t_win = 0;
        h_rdata = 32'd0; h_ok = 1'b0; h_err = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[8'(i)] = init_val(i);

        tick(); tick();
        mem_load = 1'b0;
        chk_en   = 1'b1;

        // Reset state.
        chk("rst_gnt", gnt, 4'd0);
        chk("rst_done", done, 4'd0);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_claim_ok", claim_ok, 1'b0);
        chk("rst_addr_err", addr_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_addr", mem_addr, 12'd0);
        chk("rst_mem_din", mem_din, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Read of cell 5 by requester 0.
        wait_idle();
        c0 = cyc;
        set_req(0, OP_RD, 32'd5, 32'd0);
        watch(0, c0, g, s, d, rd, ok, err);
        chk("read_gnt_cycle", g, 1);
        chk("read_mem_read_cycle", s, 1);
        chk("read_done_cycle", d, 3);
        chk("read_rdata", rd, 32'd7);

        // Claim race on cell 20.
        wait_idle();
        c0 = cyc;
        set_req(1, OP_CL, 32'd20, 32'd1);
        set_req(2, OP_CL, 32'd20, 32'd2);
        watch(1, c0, g, s, d, rd, ok, err);
        chk("claim1_gnt_cycle", g, 1);
        chk("claim1_done_cycle", d, 4);
        chk("claim1_ok", ok, 1'b1);
        chk("claim1_rdata", rd, 32'hFFFF_FFFF);
        watch(2, c0, g, s, d, rd, ok, err);
        chk("claim2_gnt_cycle", g, 6);
        chk("claim2_done_cycle", d, 8);
        chk("claim2_ok", ok, 1'b0);
        chk("claim2_rdata", rd, 32'd1);
        chk("cell20_value", env_mem[20], 32'd1);

        // Address errors, below and above the grid.
        wait_idle();
        c0 = cyc;
        set_req(3, OP_RD, 32'hFFFF_FFFF, 32'd0);
        watch(3, c0, g, s, d, rd, ok, err);
        chk("neg_addr_done_cycle", d, 2);
        chk("neg_addr_err", err, 1'b1);
        chk("neg_addr_strobe", s, -1);
        chk("neg_addr_rdata", rd, 32'd0);
        wait_idle();
        c0 = cyc;
        set_req(3, OP_CL, 32'd144, 32'd9);
        watch(3, c0, g, s, d, rd, ok, err);
        chk("hi_addr_done_cycle", d, 2);
        chk("hi_addr_err", err, 1'b1);
        chk("hi_addr_strobe", s, -1);
        chk("hi_addr_claim_ok", ok, 1'b0);

        // Fairness with every request held high.
        wait_idle();
        auto_drop = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, OP_RD, 32'(i + 1), 32'd0);
        cnt = 0;
        for (int n = 0; n < 40 && cnt < 5; n++) begin
            tick();
            for (int j = 0; j < NREQ; j++) if (gnt[j]) begin
                order[cnt] = j;
                cnt++;
            end
            if (cnt >= 5) req = '0;
        end
        req = '0;
        auto_drop = 1'b1;
        chk("fair_count", cnt, 5);
        for (int k = 0; k < 5; k++) chk($sformatf("fair_order_%0d", k), order[k], exp_order[k]);

        // Reset while a claim waits for read data.
        wait_idle();
        c0 = cyc;
        set_req(0, OP_CL, 32'd24, 32'h55);
        tick();
        tick();
        chk("abort_busy_before", busy, 1'b1);
        reset = 1'b0;
        tick();
        chk("abort_gnt", gnt, 4'd0);
        chk("abort_done", done, 4'd0);
        chk("abort_mem_write", mem_write, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_rdata", rdata, 32'd0);
        chk("abort_mem_addr", mem_addr, 12'd0);
        chk("abort_mem_din", mem_din, 32'd0);
        reset = 1'b1;
        tick();
        tick();
        chk("cell24_untouched", env_mem[24], 32'hFFFF_FFFF);
        wait_idle();
        c0 = cyc;
        set_req(2, OP_RD, 32'd3, 32'd0);
        set_req(0, OP_RD, 32'd24, 32'd0);
        watch(0, c0, g, s, d, rd, ok, err);
        chk("post_reset_first_gnt", g, 1);
        chk("post_reset_rdata", rd, 32'hFFFF_FFFF);
        wait_idle();
        tick();
        wait_idle();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i]) begin
                    if (($urandom % 4) == 0) set_req(i, 2'($urandom % 4), rand_addr(), rand_data());
                end else if (($urandom % 32) == 0) begin
                    req[i] = 1'b0;
                end else if (($urandom % 16) == 0) begin
                    set_req(i, 2'($urandom % 4), rand_addr(), rand_data());
                end
            end
        end
        req = '0;
        tick();
        wait_idle();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/grid_port_arbiter.md
GRID_PORT_ARBITER -- requirements
Module: grid_port_arbiter

Interface
REQ-001 Parameters SHALL be: NREQ, default 4, number of requesters; DW, default 32, data width; DEPTH, default 144, grid cells (n*n, n=12); AW, default 12, memory address width.
REQ-002 Clock and reset SHALL be: one clock, clk; reset is synchronous and active-low, named reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 req  input  NREQ  per-requester request, held high until the matching gnt pulse.
REQ-006 op  input  2*NREQ  per-requester opcode: 00 read, 01 write, 10 claim (test-and-set if the cell is empty), 11 reserved (treated as read).
REQ-007 addr  input  32*NREQ  per-requester signed cell index.
REQ-008 wdata  input  DW*NREQ  per-requester write/claim data.
REQ-009 gnt  output  NREQ  one-hot, one-cycle pulse when a request is accepted.
REQ-010 done  output  NREQ  one-hot, one-cycle completion pulse to the granted requester.
REQ-011 rdata  output  DW  read value (read/claim: old cell value), valid while done is high.
REQ-012 claim_ok  output  1  claim succeeded, valid while done is high.
REQ-013 addr_err  output  1  address out of range, valid while done is high.
REQ-014 mem_read, mem_write  output  1 each  memory strobes; mem_addr  output  AW; mem_din  output  DW.
REQ-015 mem_dout  input  DW  memory read data, valid the cycle after mem_read.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, RD_WAIT, CLAIM_WR, DONE; all outputs are decoded from registered state and latched fields.
REQ-018 In IDLE, if any req is high, the block SHALL pick a winner round-robin starting at pointer rr, latch its op, addr and wdata, and go to ISSUE; otherwise it stays in IDLE.
REQ-019 gnt[winner] SHALL be high only during the ISSUE cycle.
REQ-020 ISSUE, in-range address: read/claim assert mem_read, then go to RD_WAIT; write asserts mem_write with mem_din=wdata, then goes to DONE.
REQ-021 ISSUE, addr<0 or addr>=DEPTH: no memory strobe; go to DONE with addr_err=1, rdata=0, claim_ok=0.
REQ-022 RD_WAIT SHALL capture mem_dout into rdata. A read then goes to DONE. A claim goes to CLAIM_WR if mem_dout equals -1 (all ones); otherwise it goes to DONE with claim_ok=0.
REQ-023 CLAIM_WR SHALL assert mem_write with mem_din=wdata at the latched address, set claim_ok=1, and go to DONE.
REQ-024 DONE SHALL pulse done[winner] for one cycle, set rr=(winner+1) mod NREQ, and return to IDLE.
REQ-025 Latency, measured from the IDLE cycle in which req is sampled (cycle 0): write done=cycle 2; read done=cycle 3; claim-fail done=cycle 3; claim-success done=cycle 4; address error done=cycle 2.
REQ-026 Only one transaction SHALL be outstanding, so the read-check-write of a claim is atomic against all other requesters.
REQ-027 Requests arriving or changing while busy SHALL be ignored until IDLE.
REQ-028 A req dropped before gnt SHALL be ignored with no side effect.
REQ-029 A req still high in the IDLE cycle after done SHALL be treated as a new request.
REQ-030 Simultaneous requests SHALL be granted in rotating order; no requester waits more than NREQ transactions.
REQ-031 mem_addr SHALL be the low AW bits of the latched addr; rdata, claim_ok and addr_err hold their values until the next DONE.

Reset
REQ-032 While reset=0 at a clock edge, the block SHALL go to IDLE with rr=0 and gnt, done, mem_read, mem_write, claim_ok, addr_err, busy all 0, and mem_addr, mem_din, rdata all 0.
REQ-033 Reset asserted mid-transaction SHALL abort it with no done pulse; a pending claim write SHALL NOT be issued.

Structure
REQ-034 Shared package grid_arb_pkg SHALL hold NREQ, DW, DEPTH, AW, EMPTY_CELL (-1), the opcode constants and the FSM state encoding.
REQ-035 One sub-module rr_picker SHALL map a request vector and pointer to a one-hot winner and its index, purely combinational.

Verification
REQ-036 Read: req0 read addr 5, cell 5 = 7 -> gnt0 at cycle 1, mem_read at cycle 1, done0 at cycle 3 with rdata=7.
REQ-037 Claim race: req1 and req2 both claim addr 20 (cell -1) with wdata 1 and 2 -> req1 gets claim_ok=1 and the cell becomes 1; req2 then gets claim_ok=0 with rdata=1.
REQ-038 Fairness: all four req held high continuously with rr=0 -> grant order 0,1,2,3,0.
REQ-039 Address error: addr -1 and addr 144 -> no mem strobe, done with addr_err=1 at cycle 2.
REQ-040 Reset during RD_WAIT of a claim -> no mem_write, no done, outputs 0, next grant goes to requester 0.
